spi_master_mc: RTL

Next-generation SPI master for the spi_top subsystem. It supports width-parametrised frames, runtime-selectable SPI mode (CPOL/CPHA), MSB- or LSB-first ordering, a programmable SCLK divider, and NUM_CS one-hot active-low chip selects. It sits between a host request interface and an external slave bus. It adds per-transfer mode and chip-select selection and a programmable inter-frame gap, none of which the single-mode master has.

---
 rtl/spi_master_mc.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_mc.sv
// SPI master with runtime CPOL/CPHA, bit order, SCLK divider, one-hot chip selects and an
// inter-frame gap. All outputs are registered; every frame parameter is captured on start.
module spi_master_mc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CS     = 4,
  parameter int unsigned DIV_W      = 8,
  localparam int unsigned CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CSW-1:0]        cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_W-1:0]      clk_div,
  input  logic [7:0]            wait_duration,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [NUM_CS-1:0]     cs_n,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  done,
  output logic                  cs_err,
  output logic                  busy
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam int unsigned EW = BW + 1;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d, div_q, div_d;
  logic [EW-1:0]           edge_q, edge_d;
  logic [7:0]              gap_q, gap_d, wait_q, wait_d;
  logic                    cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, cs_ok_q, cs_ok_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic                    sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
  logic                    cs_err_q, cs_err_d, busy_q, busy_d;
  logic [NUM_CS-1:0]       cs_n_q, cs_n_d;
  logic [BW-1:0]           bit_n;
  logic                    leading;
  logic                    cs_ok;

  // Maps the n-th transferred bit to its position in the word for the latched bit order.
  function automatic logic [BW-1:0] bit_pos(input logic lsb, input logic [BW-1:0] idx);
    return lsb ? idx : BW'(DATA_WIDTH - 1) - idx;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    edge_d   = edge_q;
    gap_d    = gap_q;
    wait_d   = wait_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    lsb_d    = lsb_q;
    cs_ok_d  = cs_ok_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    dout_d   = dout_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cs_err_d = 1'b0;
    bit_n    = edge_q[EW-1:1];
    leading  = ~edge_q[0];
    cs_ok    = 32'(cs_sel) < NUM_CS;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          cnt_d   = '0;
          div_d   = clk_div;
          wait_d  = wait_duration;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          cs_ok_d = cs_ok;
          tx_d    = din;
          rx_d    = '0;
          sclk_d  = cpol;
          busy_d  = 1'b1;
          cs_n_d  = cs_ok ? ~(NUM_CS'(1) << cs_sel) : '1;
          mosi_d  = cs_ok & (lsb_first ? din[0] : din[DATA_WIDTH-1]);
        end
      end
      StSetup: begin
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          edge_d  = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == div_q) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (leading ^ cpha_q) begin
            rx_d[bit_pos(lsb_q, bit_n)] = miso;
          end else if (cpha_q) begin
            mosi_d = cs_ok_q & tx_q[bit_pos(lsb_q, bit_n)];
          end else if (bit_n != BW'(DATA_WIDTH - 1)) begin
            mosi_d = cs_ok_q & tx_q[bit_pos(lsb_q, bit_n + 1'b1)];
          end
          if (edge_q == EW'(2 * DATA_WIDTH - 1)) state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == div_q) begin
          cnt_d    = '0;
          cs_n_d   = '1;
          mosi_d   = 1'b0;
          dout_d   = rx_q;
          done_d   = 1'b1;
          cs_err_d = ~cs_ok_q;
          gap_d    = '0;
          if (wait_q == 8'd0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == wait_q - 8'd1) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      div_q    <= '0;
      edge_q   <= '0;
      gap_q    <= '0;
      wait_q   <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      cs_ok_q  <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      dout_q   <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      edge_q   <= edge_d;
      gap_q    <= gap_d;
      wait_q   <= wait_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      lsb_q    <= lsb_d;
      cs_ok_q  <= cs_ok_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      dout_q   <= dout_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_err_q <= cs_err_d;
    end
  end

  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign cs_n   = cs_n_q;
  assign dout   = dout_q;
  assign done   = done_q;
  assign cs_err = cs_err_q;
  assign busy   = busy_q;

endmodule
